fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drain-side companion for the team's latency-configurable simple-DP-RAM FIFO. It pops words from the FIFO's `read`/`read_data` port, tracks reads still in the FIFO's read pipeline, and captures returned words into a small local buffer. It presents that buffer to a downstream consumer as a valid/ready stream. It sits between the FIFO output and any stream sink, so no sink ever has to know the FIFO read latency.

## Interface
- `DATA_WIDTH`, default 8: word width; must equal the FIFO data width.
- `LATENCY`, default 3: FIFO read latency in cycles. Minimum 2. Must equal the FIFO's `LATENCY`.
- `BUF_DEPTH`, default 5: local buffer entries, power of two not required. Must be at least `LATENCY+1`; full rate needs at least `LATENCY+2`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: permits issuing new FIFO reads.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read` out 1: FIFO read strobe.
- `fifo_read_data` in DATA_WIDTH: FIFO read data, valid exactly `LATENCY` cycles after the cycle `fifo_read` was high.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_WIDTH: output word.
- `busy` out 1: high when in-flight count or buffer count is non-zero.
- `pop_count` out 16: present only with `FIFO_STREAM_READER_STATS_EN`; see Configuration.

## Operation
- **In-flight tracker:** `vpipe[LATENCY-1:0]` is a shift register. `vpipe[0] <= fifo_read` each cycle, and each later stage shifts from the previous one. `inflight` is the number of ones in `vpipe`.
- **Read issue (combinational):** `fifo_read = enable & !fifo_empty & (buf_count + inflight < BUF_DEPTH)`.
  - All terms are registered state or inputs.
  - A pop in the same cycle does not free credit until the next cycle.
  - The buffer can therefore never overflow. Overflow is a bench assertion.
  - Never read while `fifo_empty` is high. The FIFO's read-while-empty pointer behaviour is never exercised.
- **Capture:** when `vpipe[LATENCY-1]` is high, write `fifo_read_data` into the buffer at `wr_idx` at the clock edge.
- **Buffer:** circular, `BUF_DEPTH` entries.
  - `wr_idx` and `rd_idx` wrap from `BUF_DEPTH-1` to 0.
  - `buf_count` has width `$clog2(BUF_DEPTH+1)`.
- **Output:**
  - `m_valid = (buf_count != 0)`.
  - `m_data = buf[rd_idx]` when valid; 0 when the buffer is empty.
  - A handshake (`m_valid & m_ready`) advances `rd_idx`.
- **Simultaneous capture and pop:** `buf_count` is unchanged, and both indices advance.
- **`enable` deasserted:** no new reads are issued. In-flight reads still complete and are captured, and the buffer keeps draining.
- **Ordering:** words leave in exactly the order they were read from the FIFO. Nothing is dropped or duplicated.

## Timing
- **Reset values** (immediately on `reset_n` low, asynchronous):
  - `fifo_read` 0, `m_valid` 0, `m_data` 0, `busy` 0, `pop_count` 0.
  - `vpipe`, indices and counts are all 0.
- **Reset mid-operation:** in-flight and buffered words are discarded. The FIFO-side pointers are the system's responsibility and are reset together with this block.
- **Latency:** a read issued in cycle t returns data on `fifo_read_data` in cycle t+`LATENCY`. `m_valid` rises in cycle t+`LATENCY`+1.
- **Throughput:** one word per cycle sustained when `BUF_DEPTH` is at least `LATENCY+2` and `m_ready` is held high. Steady-state occupancy is then `LATENCY+1`.
- **Stall:** with `m_ready`=0, reads stop once `buf_count + inflight` reaches `BUF_DEPTH`. `fifo_read` stays low until a pop is registered; the earliest new read is the cycle after that pop.
- **Output stability:** `m_data` is stable while `m_valid` is high and `m_ready` is low.

## Configuration
- **`FIFO_STREAM_READER_STATS_EN` defined:**
  - Adds the `pop_count[15:0]` output.
  - It increments on every output handshake and saturates at 0xFFFF.
  - It is cleared only by reset.
- **Not defined:** the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use `LATENCY`=3 and `BUF_DEPTH`=5.

- **Reset:** assert `reset_n`=0 mid-stream with the buffer holding 3 words → `fifo_read`, `m_valid`, `busy`, `m_data` are 0 immediately. After release, no stale word ever appears.
- **Streaming:** FIFO holds 0x11,0x22,0x33; `enable`=1, `m_ready`=1, first read in cycle 0 → reads in cycles 0–2. `m_data` is 0x11, 0x22, 0x33 in cycles 4–6 with `m_valid` high. `busy` drops in cycle 7.
- **Back-pressure:** FIFO holds 8 words, `m_ready`=0 → exactly 5 reads are issued, then `fifo_read` stays 0. Raising `m_ready` yields all 8 words in order with no gap after the first 5 except the credit refill.
- **Empty:** `fifo_empty`=1 for 10 cycles with `enable`=1 → `fifo_read` is never high. A later single word appears 4 cycles after its read.
- **Enable drop:** `enable` falls in the cycle after 2 reads were issued → both words are still delivered, and no further reads occur.
- **Stats** (macro defined): force 65 540 handshakes → `pop_count` reads 0xFFFF and holds.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//
// Valid/ready stream carrying one data word per handshake.
//   valid : producer has a word on data
//   ready : consumer accepts the word this cycle
//   data  : DATA_WIDTH-bit word, stable while valid is high and ready is low
// Modports: master (stream producer), slave (stream consumer).
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Drains a fixed-latency FIFO read port into a small circular buffer and
// presents the buffered words as a valid/ready stream, hiding the FIFO read
// latency from the downstream sink. Reads are issued only when the buffer is
// guaranteed to have room for every read still in flight.
//
// Parameters:
//   DATA_WIDTH : word width, equal to the FIFO data width
//   LATENCY    : FIFO read latency in cycles (>= 2)
//   BUF_DEPTH  : local buffer entries (>= LATENCY+1, >= LATENCY+2 for full rate)
//
// Ports:
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   enable         : permits issuing new FIFO reads
//   fifo_empty     : FIFO empty flag
//   fifo_read      : FIFO read strobe
//   fifo_read_data : FIFO read data, valid LATENCY cycles after fifo_read
//   m              : output stream (master modport: valid, data out; ready in)
//   busy           : reads in flight or words buffered
//   pop_count      : saturating count of output handshakes, only when the
//                    macro FIFO_STREAM_READER_STATS_EN is defined
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 3,
    parameter int BUF_DEPTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    fifo_stream_reader_if.master  m,
`ifdef FIFO_STREAM_READER_STATS_EN
    output logic [15:0]           pop_count,
`endif
    output logic                  busy
);

    localparam int IW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNTW = $clog2(BUF_DEPTH + 1);
    localparam int INFW = $clog2(LATENCY + 1);
    localparam int SUMW = $clog2(BUF_DEPTH + LATENCY + 1) + 1;

    logic [LATENCY-1:0]    vpipe;
    logic [INFW-1:0]       inflight;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;
    logic [CNTW-1:0]       buf_count;
    logic [DATA_WIDTH-1:0] buf_mem [0:BUF_DEPTH-1];
    logic                  credit_ok;
    logic                  capture;
    logic                  pop;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Number of reads issued but not yet returned by the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + INFW'(vpipe[i]);
        end
    end

    // Credit counts every buffered word plus every read still in flight, so
    // a read is only issued when its data is certain to find a free slot.
    // A pop this cycle frees its slot only once buf_count has updated.
    assign credit_ok = (SUMW'(buf_count) + SUMW'(inflight)) < SUMW'(BUF_DEPTH);
    assign fifo_read = enable & ~fifo_empty & credit_ok;

    assign capture = vpipe[LATENCY-1];
    assign pop     = m.valid & m.ready;

    assign m.valid = (buf_count != '0);
    assign m.data  = m.valid ? buf_mem[rd_idx] : '0;
    assign busy    = (inflight != '0) | (buf_count != '0);

    // Read-tracking pipeline, buffer indices and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vpipe     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            buf_count <= '0;
        end else begin
            if (LATENCY > 1) begin
                vpipe <= {vpipe[LATENCY-2:0], fifo_read};
            end else begin
                vpipe <= fifo_read;
            end
            if (capture) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end
            case ({capture, pop})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Buffer storage needs no reset: an entry is only visible through m.data
    // after it has been written by a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_mem[wr_idx] <= fifo_read_data;
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    // Output handshake counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_count <= '0;
        end else if (pop && (pop_count != 16'hFFFF)) begin
            pop_count <= pop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Bench for fifo_stream_reader with LATENCY=3, BUF_DEPTH=5. A behavioural
// FIFO model feeds the read port; every word it hands out is pushed to a
// scoreboard and compared when the DUT delivers it on the output stream.
module tb_fifo_stream_reader;

    localparam int DW    = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_read;
    logic [DW-1:0] fifo_read_data;
    logic          busy;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [15:0]   pop_count;
`endif

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .LATENCY   (LAT),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .fifo_read_data(fifo_read_data),
        .m             (s_if),
`ifdef FIFO_STREAM_READER_STATS_EN
        .pop_count     (pop_count),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reads_seen = 0;
    int hs_count = 0;
    int first_hs_cyc = 0;
    int last_hs_cyc = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] rd_pipe [LAT];
    bit            gen_mode = 1'b0;
    logic [DW-1:0] gen_val = '0;

    assign fifo_read_data = rd_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic void refresh_empty();
        fifo_empty = !gen_mode && (fifo_q.size() == 0);
    endfunction

    // Inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic en, input logic rdy);
        @(posedge clk);
        #1;
        enable     = en;
        s_if.ready = rdy;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refresh_empty();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        fifo_q.delete();
        sb.delete();
        gen_mode = 1'b0;
        refresh_empty();
        repeat (2) @(posedge clk);
        #1;
        enable     = 1'b0;
        s_if.ready = 1'b0;
        reset_n    = 1'b1;
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: pops on fifo_read and returns the word LAT cycles later;
    // junk is shifted in on idle cycles so a mistimed capture shows up.
    always @(posedge clk) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        if (reset_n && fifo_read) begin
            if (gen_mode) begin
                w = gen_val;
                gen_val = gen_val + 1'b1;
            end else if (fifo_q.size() == 0) begin
                checkOutput("read_while_empty", 32'd1, 32'd0);
            end else begin
                w = fifo_q.pop_front();
            end
            sb.push_back(w);
        end
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= w;
        fifo_empty <= !gen_mode && (fifo_q.size() == 0);
    end

    // Output monitor and scoreboard check, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (fifo_read) reads_seen++;
            if (s_if.valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL stale_word actual=%0h required=none (cycle %0d)",
                             s_if.data, cyc);
                end else begin
                    checkOutput("m_data_order", 32'(s_if.data), 32'(sb[0]));
                    if (s_if.ready) begin
                        void'(sb.pop_front());
                        if (hs_count == 0) first_hs_cyc = cyc;
                        hs_count++;
                        last_hs_cyc = cyc;
                    end
                end
            end else begin
                checkOutput("m_data_idle_zero", 32'(s_if.data), 32'd0);
            end
            checkOutput("no_overflow", 32'(sb.size() > DEPTH), 32'd0);
        end
    end

    typedef struct {
        logic          en;
        logic          rdy;
        logic          exp_read;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int rc;
        int vc;
        int rcyc;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        reset_n    = 1'b1;
        enable     = 1'b0;
        s_if.ready = 1'b0;
        fifo_empty = 1'b1;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;

        // Power-on reset
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_fifo_read", 32'(fifo_read), 32'd0);
        checkOutput("reset_m_valid", 32'(s_if.valid), 32'd0);
        checkOutput("reset_m_data", 32'(s_if.data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Streaming: three words, cycle-exact table
        $display("[TB] streaming");
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].en, tbl[i].rdy);
            @(negedge clk);
            checkOutput($sformatf("stream_read_c%0d", i), 32'(fifo_read), 32'(tbl[i].exp_read));
            checkOutput($sformatf("stream_valid_c%0d", i), 32'(s_if.valid), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("stream_data_c%0d", i), 32'(s_if.data), 32'(tbl[i].exp_data));
            checkOutput($sformatf("stream_busy_c%0d", i), 32'(busy), 32'(tbl[i].exp_busy));
        end

        // Back-pressure: 8 words, consumer stalled
        $display("[TB] back-pressure");
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        applyStimulus(1'b1, 1'b0);
        reads_seen = 0;
        repeat (15) @(negedge clk);
        checkOutput("bp_reads_while_stalled", 32'(reads_seen), 32'd5);
        checkOutput("bp_busy_stalled", 32'(busy), 32'd1);
        hs_count = 0;
        applyStimulus(1'b1, 1'b1);
        rcyc = cyc;
        for (int k = 0; k < 40 && hs_count < 8; k++) @(negedge clk);
        checkOutput("bp_words_delivered", 32'(hs_count), 32'd8);
        checkOutput("bp_first_word_cycle", 32'(first_hs_cyc - rcyc), 32'd0);
        checkOutput("bp_no_gap_span", 32'(last_hs_cyc - first_hs_cyc), 32'd7);

        // Empty FIFO: no reads, then a single word with 4-cycle latency
        $display("[TB] empty");
        do_reset();
        applyStimulus(1'b1, 1'b1);
        reads_seen = 0;
        repeat (10) @(negedge clk);
        checkOutput("empty_no_reads", 32'(reads_seen), 32'd0);
        @(posedge clk);
        #1;
        push_word(8'h5A);
        rc = cyc;
        vc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_if.valid) begin
                vc = cyc;
                break;
            end
        end
        checkOutput("empty_single_latency", 32'(vc - rc), 32'd4);
        checkOutput("empty_single_reads", 32'(reads_seen), 32'd1);

        // Enable drop after two reads
        $display("[TB] enable drop");
        do_reset();
        for (int i = 0; i < 5; i++) push_word(8'hC0 + 8'(i));
        applyStimulus(1'b1, 1'b1);
        reads_seen = 0;
        hs_count = 0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("endrop_reads", 32'(reads_seen), 32'd2);
        checkOutput("endrop_delivered", 32'(hs_count), 32'd2);
        checkOutput("endrop_idle_busy", 32'(busy), 32'd0);

        // Reset mid-stream with three words buffered
        $display("[TB] reset mid-stream");
        do_reset();
        for (int i = 0; i < 3; i++) push_word(8'h81 + 8'(i));
        applyStimulus(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("mid_valid_before", 32'(s_if.valid), 32'd1);
        @(posedge clk);
        #1;
        push_word(8'hEE);
        push_word(8'hEF);
        #2;
        reset_n = 1'b0;
        fifo_q.delete();
        sb.delete();
        refresh_empty();
        #1;
        checkOutput("mid_reset_fifo_read", 32'(fifo_read), 32'd0);
        checkOutput("mid_reset_m_valid", 32'(s_if.valid), 32'd0);
        checkOutput("mid_reset_m_data", 32'(s_if.data), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hs_count = 0;
        push_word(8'h91);
        push_word(8'h92);
        applyStimulus(1'b1, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("mid_after_delivered", 32'(hs_count), 32'd2);

`ifdef FIFO_STREAM_READER_STATS_EN
        // Saturating handshake counter
        $display("[TB] stats");
        do_reset();
        @(negedge clk);
        checkOutput("stats_reset_zero", 32'(pop_count), 32'd0);
        hs_count = 0;
        gen_val  = '0;
        gen_mode = 1'b1;
        refresh_empty();
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 70000 && hs_count < 65540; k++) @(negedge clk);
        checkOutput("stats_handshakes", 32'(hs_count >= 65540), 32'd1);
        checkOutput("stats_saturated", 32'(pop_count), 32'hFFFF);
        repeat (5) @(negedge clk);
        checkOutput("stats_holds", 32'(pop_count), 32'hFFFF);
        applyStimulus(1'b0, 1'b1);
        gen_mode = 1'b0;
        refresh_empty();
        repeat (8) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
